// File: rtl/rotate_amount_finder.sv
// Recovers the rotation amount relating two words by testing one candidate per clock.
// The working copy of the reference is rotated in place until it matches the target or all amounts are exhausted.
module rotate_amount_finder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2**N-1:0] ref_data,
  input  logic [2**N-1:0] rot_data,
  input  logic         dir_lr,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [N-1:0] amt
);

  localparam int WIDTH = 2**N;
  localparam logic [N-1:0] CNT_MAX = N'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] target;
  logic [N-1:0]     cnt;
  logic             dir;
  logic [WIDTH-1:0] work_next;

  // One-step rotation of the working word in the captured direction
  always_comb begin
    work_next = work;
    if (dir) begin
      work_next = {work[WIDTH-2:0], work[WIDTH-1]};
    end else begin
      work_next = {work[0], work[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      target <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      amt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work   <= ref_data;
            target <= rot_data;
            dir    <= dir_lr;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          // Match is tested before the exhaustion check so candidate WIDTH-1 still counts
          if (work == target) begin
            found <= 1'b1;
            amt   <= cnt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else if (cnt == CNT_MAX) begin
            found <= 1'b0;
            amt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            work <= work_next;
            cnt  <= cnt + N'(1);
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
